// File: rtl/matrix_mult_pkg.sv
// Shared constants and packing helper for the 4x4 matrix multiplier.
// Elements are 16-bit unsigned, packed row-major into 256 bits.
package matrix_mult_pkg;

  localparam int N      = 4;
  localparam int ELEM_W = 16;
  localparam int ROW_W  = N * ELEM_W;
  localparam int MAT_W  = N * ROW_W;

  function automatic int elem_off(input int r, input int c);
    return r * ROW_W + c * ELEM_W;
  endfunction

endpackage

// File: rtl/matrix_mult_dot.sv
// Four-term unsigned dot product, truncated to one element width.
// Truncation gives the required modulo-2^16 wraparound for free.
module matrix_mult_dot
  import matrix_mult_pkg::*;
(
  input  logic [ROW_W-1:0]  row_i,
  input  logic [ROW_W-1:0]  col_i,
  output logic [ELEM_W-1:0] dot_o
);

  logic [ELEM_W-1:0] acc;
  logic [ELEM_W-1:0] a;
  logic [ELEM_W-1:0] b;

  always_comb begin
    acc = '0;
    a   = '0;
    b   = '0;
    for (int k = 0; k < N; k++) begin
      a   = row_i[k*ELEM_W +: ELEM_W];
      b   = col_i[k*ELEM_W +: ELEM_W];
      acc = acc + a * b;
    end
  end

  assign dot_o = acc;

endmodule

// File: rtl/matrix_mult.sv
// 4x4 combinational matrix product with a registered result-valid flag.
// The done flop is the only state in the block.
module matrix_mult
  import matrix_mult_pkg::*;
(
  output logic [MAT_W-1:0] m_out,
  output logic             done,
  input  logic [MAT_W-1:0] m1,
  input  logic [MAT_W-1:0] m2,
  input  logic             enable,
  input  logic             reset,
  input  logic             clk
);

  logic [ROW_W-1:0] col_w [N];
  logic             done_d;
  logic             done_q;

  // Gather each column of m2 into a contiguous vector
  for (genvar c = 0; c < N; c++) begin : g_col
    for (genvar k = 0; k < N; k++) begin : g_k
      assign col_w[c][k*ELEM_W +: ELEM_W] =
        m2[elem_off(k, c) +: ELEM_W];
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_r
    for (genvar c = 0; c < N; c++) begin : g_c
      matrix_mult_dot u_dot (
        .row_i (m1[r*ROW_W +: ROW_W]),
        .col_i (col_w[c]),
        .dot_o (m_out[elem_off(r, c) +: ELEM_W])
      );
    end
  end

  // X or Z on enable must read as not-requested
  assign done_d = (enable === 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= done_d;
  end

  assign done = done_q;

endmodule

// File: tb/tb_matrix_mult.sv
// Directed bench for matrix_mult: products, wraparound, done/reset timing.
module tb_matrix_mult;

  logic [255:0] m_out;
  logic         done;
  logic [255:0] m1;
  logic [255:0] m2;
  logic         enable;
  logic         reset;
  logic         clk;

  int passed = 0;
  int total  = 0;

  matrix_mult dut (
    .m_out  (m_out),
    .done   (done),
    .m1     (m1),
    .m2     (m2),
    .enable (enable),
    .reset  (reset),
    .clk    (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [15:0] mat_t [16];

  function automatic logic [255:0] pack(input mat_t e);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = e[i];
    return v;
  endfunction

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag,
                           input logic obs,
                           input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  mat_t a_m, b_m, p_m, id_m, ff_m, z_m, sq_m;
  logic [255:0] a_v, b_v, p_v, id_v, ff_v, z_v, sq_v;

  initial begin
    a_m  = '{5,8,9,2, 7,3,8,4, 6,5,4,3, 8,5,7,6};
    b_m  = '{11,14,19,18, 6,9,3,5, 12,10,15,14, 1,3,5,7};
    p_m  = '{213,238,264,270, 195,217,282,281,
             147,178,204,210, 208,245,302,309};
    id_m = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
    ff_m = '{16{16'hFFFF}};
    z_m  = '{16{16'h0000}};
    sq_m = '{16{16'h0004}};
    a_v  = pack(a_m);
    b_v  = pack(b_m);
    p_v  = pack(p_m);
    id_v = pack(id_m);
    ff_v = pack(ff_m);
    z_v  = pack(z_m);
    sq_v = pack(sq_m);

    // t=0: operands applied, reset pulse of 1ns
    m1 = a_v; m2 = b_v; enable = 1'b0; reset = 1'b1;
    #1 reset = 1'b0;
    check_bit("reset_done", done, 1'b0);

    // t=20: product valid with no enabled edge yet
    #19;
    for (int r = 0; r < 4; r++)
      check($sformatf("nominal_row%0d", r),
            {192'd0, m_out[r*64 +: 64]},
            {192'd0, p_v[r*64 +: 64]});
    check_bit("done_idle", done, 1'b0);

    m1 = id_v; m2 = b_v;
    #1 check("identity", m_out, b_v);
    m1 = ff_v; m2 = ff_v;
    #1 check("overflow", m_out, sq_v);
    m1 = z_v; m2 = a_v;
    #1 check("zero", m_out, z_v);
    m1 = a_v; m2 = id_v;
    #1 check("right_identity", m_out, a_v);
    m1 = a_v; m2 = b_v;

    // enable raised 5ns after an edge
    @(posedge clk);
    #5 enable = 1'b1;
    #1 check_bit("done_before_edge", done, 1'b0);
    @(posedge clk);
    #1 check_bit("done_rise", done, 1'b1);
    m2 = id_v;
    #1 check("product_while_done", m_out, a_v);
    check_bit("done_hold_on_change", done, 1'b1);
    @(posedge clk);
    #1 check_bit("done_stays", done, 1'b1);

    // short reset between edges
    #2 reset = 1'b1;
    #1 check_bit("reset_mid_done", done, 1'b0);
    check("reset_mid_mout", m_out, a_v);
    #1 reset = 1'b0;
    #1 check_bit("done_low_until_edge", done, 1'b0);
    @(posedge clk);
    #1 check_bit("done_recover", done, 1'b1);

    // reset held across an edge keeps done low
    reset = 1'b1;
    @(posedge clk);
    #1 check_bit("reset_held", done, 1'b0);
    check("reset_held_mout", m_out, a_v);
    reset = 1'b0;
    @(posedge clk);
    #1 check_bit("done_after_release", done, 1'b1);

    // enable dropped
    enable = 1'b0;
    #1 check_bit("done_before_drop_edge", done, 1'b1);
    @(posedge clk);
    #1 check_bit("done_fall", done, 1'b0);
    check("mout_after_drop", m_out, a_v);

    // unknown enable reads as not-requested
    enable = 1'b1;
    @(posedge clk);
    #1 check_bit("done_rise2", done, 1'b1);
    enable = 1'bx;
    @(posedge clk);
    #1 check_bit("done_on_x", done, 1'b0);
    enable = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
